exu_addi_datapath: RTL and testbench
====================================

Name: exu_addi_datapath

Overview:
- Minimal single-cycle execute datapath for the RV64 core.
- Holds the 32x64 general-purpose register file and computes rd = rs1 + imm_I for the ADDI key opcode.
- Write-enable and write-data are selected by a key-match multiplexer on the decoded opcode.
- Also produces the sequential next PC (pc + 4). Sits between the decode stage (imm/rd/rs1/rs2/opcode) and PC update.

Parameters:
- ADDR_W, 5, register index width (2**ADDR_W registers).
- DATA_W, 64, register/datapath width.
- OP_W, 10, decoded opcode key width.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  asynchronous active-high reset.
- imm_I  in  DATA_W  sign-extended I-type immediate.
- rd  in  ADDR_W  destination register index.
- rs1  in  ADDR_W  source register 1 index.
- rs2  in  ADDR_W  source register 2 index.
- opcode  in  OP_W  decoded opcode key.
- pc  in  DATA_W  current instruction address.
- dnpc  out  DATA_W  next PC = pc + 4.
- src1  out  DATA_W  combinational read data for rs1.
- src2  out  DATA_W  combinational read data for rs2.
- sum  out  DATA_W  imm_I + src1.
- wdata  out  DATA_W  selected write data.
- wen  out  1  selected write enable.

Behaviour:
- Reset:
  - Asynchronous active-high: while rst=1, all 32 registers are 0.
  - Release is synchronous to clk usage; the first write can occur on the first rising edge with rst=0.
  - Outputs are combinational, so during reset src1=src2=0, sum=imm_I, and dnpc=pc+4.
- dnpc = pc + 64'd4, modulo 2**64 (0xFFFF_FFFF_FFFF_FFFC -> 0).
- sum = imm_I + src1, modulo 2**DATA_W, carry discarded.
- Key mux, one entry:
  - opcode == 10'b00_0000_0001 (ADDI): wen=1, wdata=sum.
  - Any other opcode (no key match): wen=0, wdata=0.
- Register file reads:
  - Two asynchronous read ports; src1=reg[rs1], src2=reg[rs2].
  - Register 0 always reads 0.
- Register file write:
  - On posedge clk with rst=0 and wen=1 and rd!=0: reg[rd] <= wdata.
  - Writes to rd=0 are discarded.
- Latency:
  - Write visible on src1/src2 immediately after the clock edge.
  - Same-cycle read of the register being written returns the old value (no bypass).
- rs1==rs2: both ports return the same value.
- rst asserted mid-operation clears all registers immediately, without waiting for a clock edge, and overrides any pending write.
- No handshake; one instruction per cycle.

Decomposition:
- Shared package: OP_ADDI = 10'b1, ADDR_W/DATA_W/OP_W defaults, reset value 0.
- Sub-module key_mux, parameterised:
  - Parameters: entry count, key width, data width, default value.
  - Input: flat {key,data} list; output: data of the matching key, else the default.
  - Instantiated twice, once for wen and once for wdata.
- The register file is the other natural sub-module (gpr_file); the adder stays inline.

Test Plan:
- Reset, then read all indices:
  - Assert rst mid-cycle after writing x5: src1 returns 0 immediately.
  - After release, rs1=0..31 all read 0.
- ADDI write:
  - rs1=0, imm=42, rd=3, opcode=ADDI, one edge -> x3=42.
  - Then rs1=3, imm=-2 (0xFFFF_FFFF_FFFF_FFFE), rd=4 -> x4=40, sum=40 before the edge.
- Non-ADDI opcode:
  - opcode=10'b10, rd=6, imm=7 -> wen=0, wdata=0.
  - x6 unchanged (0) after the edge.
- x0 protection: ADDI rd=0, imm=99 -> src1 with rs1=0 still 0 after the edge.
- Wrap and no bypass:
  - x7=0xFFFF_FFFF_FFFF_FFFF, then ADDI rd=7, rs1=7, imm=1.
  - Before the edge src1=all-ones and sum=0; after the edge x7=0.
- dnpc:
  - pc=0x8000_0000 -> dnpc=0x8000_0004.
  - pc=0xFFFF_FFFF_FFFF_FFFC -> dnpc=0.

Source files
------------

// File: rtl/exu_addi_datapath_pkg.sv
// Shared constants for the ADDI execute datapath: default widths, opcode keys, reset value.
package exu_addi_datapath_pkg;

   localparam int unsigned DEF_ADDR_W = 5;
   localparam int unsigned DEF_DATA_W = 64;
   localparam int unsigned DEF_OP_W   = 10;

   localparam logic [DEF_OP_W-1:0]   OP_ADDI   = 10'b00_0000_0001;
   localparam logic [DEF_DATA_W-1:0] GPR_RST_V = '0;

endpackage

// File: rtl/exu_addi_datapath_gpr_file.sv
// General-purpose register file: two async read ports, one write port, x0 hardwired to zero.
module gpr_file
   import exu_addi_datapath_pkg::*;
#(
   parameter int unsigned ADDR_W = DEF_ADDR_W,
   parameter int unsigned DATA_W = DEF_DATA_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wen_i,
   input  logic [ADDR_W-1:0] waddr_i,
   input  logic [DATA_W-1:0] wdata_i,
   input  logic [ADDR_W-1:0] raddr1_i,
   input  logic [ADDR_W-1:0] raddr2_i,
   output logic [DATA_W-1:0] rdata1_o,
   output logic [DATA_W-1:0] rdata2_o
);

   localparam int unsigned NR_REG = 2 ** ADDR_W;

   logic [DATA_W-1:0] regs_q [NR_REG];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < int'(NR_REG); i++) begin
            regs_q[i] <= DATA_W'(GPR_RST_V);
         end
      end else if (wen_i && (waddr_i != '0)) begin
         regs_q[waddr_i] <= wdata_i;
      end
   end

   // No write bypass: a same-cycle read of the written index returns the old value.
   assign rdata1_o = (raddr1_i == '0) ? '0 : regs_q[raddr1_i];
   assign rdata2_o = (raddr2_i == '0) ? '0 : regs_q[raddr2_i];

endmodule

// File: rtl/exu_addi_datapath_key_mux.sv
// Key-match multiplexer: returns the data of the entry whose key equals key_i, else DEFAULT.
module key_mux #(
   parameter int unsigned          NR_KEY = 1,
   parameter int unsigned          KEY_W  = 1,
   parameter int unsigned          DATA_W = 1,
   parameter logic [DATA_W-1:0]    DEFAULT = '0
) (
   input  logic [NR_KEY*(KEY_W+DATA_W)-1:0] lut_i,
   input  logic [KEY_W-1:0]                 key_i,
   output logic [DATA_W-1:0]                data_o
);

   localparam int unsigned ENT_W = KEY_W + DATA_W;

   // Each entry is packed as {key, data}; entry 0 sits in the low bits.
   always_comb begin
      data_o = DEFAULT;
      for (int i = 0; i < int'(NR_KEY); i++) begin
         if (lut_i[i*ENT_W+DATA_W +: KEY_W] == key_i) begin
            data_o = lut_i[i*ENT_W +: DATA_W];
         end
      end
   end

endmodule

// File: rtl/exu_addi_datapath.sv
// Single-cycle execute datapath: GPR file, rd = rs1 + imm_I for ADDI, and sequential next PC.
module exu_addi_datapath
   import exu_addi_datapath_pkg::*;
#(
   parameter int unsigned ADDR_W = DEF_ADDR_W,
   parameter int unsigned DATA_W = DEF_DATA_W,
   parameter int unsigned OP_W   = DEF_OP_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] imm_I,
   input  logic [ADDR_W-1:0] rd,
   input  logic [ADDR_W-1:0] rs1,
   input  logic [ADDR_W-1:0] rs2,
   input  logic [OP_W-1:0]   opcode,
   input  logic [DATA_W-1:0] pc,
   output logic [DATA_W-1:0] dnpc,
   output logic [DATA_W-1:0] src1,
   output logic [DATA_W-1:0] src2,
   output logic [DATA_W-1:0] sum,
   output logic [DATA_W-1:0] wdata,
   output logic              wen
);

   assign dnpc = pc + DATA_W'(4);
   assign sum  = imm_I + src1;

   key_mux #(
      .NR_KEY  (1),
      .KEY_W   (OP_W),
      .DATA_W  (1),
      .DEFAULT (1'b0)
   ) u_wen_mux (
      .lut_i  ({OP_W'(OP_ADDI), 1'b1}),
      .key_i  (opcode),
      .data_o (wen)
   );

   key_mux #(
      .NR_KEY  (1),
      .KEY_W   (OP_W),
      .DATA_W  (DATA_W),
      .DEFAULT ('0)
   ) u_wdata_mux (
      .lut_i  ({OP_W'(OP_ADDI), sum}),
      .key_i  (opcode),
      .data_o (wdata)
   );

   gpr_file #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_gpr_file (
      .clk      (clk),
      .rst      (rst),
      .wen_i    (wen),
      .waddr_i  (rd),
      .wdata_i  (wdata),
      .raddr1_i (rs1),
      .raddr2_i (rs2),
      .rdata1_o (src1),
      .rdata2_o (src2)
   );

endmodule

// File: tb/tb_exu_addi_datapath.sv
// Bench for exu_addi_datapath: directed scenarios plus random instructions against an array model.
module tb_exu_addi_datapath;

   logic        clk = 1'b0;
   logic        rst;
   logic [63:0] imm_I;
   logic [4:0]  rd, rs1, rs2;
   logic [9:0]  opcode;
   logic [63:0] pc;
   logic [63:0] dnpc, src1, src2, sum, wdata;
   logic        wen;

   logic [63:0] model [32];
   int          pass_cnt  = 0;
   int          check_cnt = 0;

   exu_addi_datapath dut (
      .clk    (clk),
      .rst    (rst),
      .imm_I  (imm_I),
      .rd     (rd),
      .rs1    (rs1),
      .rs2    (rs2),
      .opcode (opcode),
      .pc     (pc),
      .dnpc   (dnpc),
      .src1   (src1),
      .src2   (src2),
      .sum    (sum),
      .wdata  (wdata),
      .wen    (wen)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      check_cnt++;
      assert (obs === exp) pass_cnt++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   function automatic logic [63:0] rd_model(input logic [4:0] idx);
      return (idx == 5'd0) ? 64'd0 : model[idx];
   endfunction

   task automatic clear_model();
      for (int i = 0; i < 32; i++) model[i] = 64'd0;
   endtask

   // Drive one instruction, check combinational outputs, clock it, and retire it in the model.
   task automatic instr(input logic [9:0] op, input logic [4:0] d, input logic [4:0] a,
                        input logic [4:0] b, input logic [63:0] im, input logic [63:0] p);
      logic [63:0] exp_sum;
      logic        is_addi;
      opcode = op; rd = d; rs1 = a; rs2 = b; imm_I = im; pc = p;
      #1;
      exp_sum = im + rd_model(a);
      is_addi = (op == 10'd1);
      chk("src1",  src1,  rd_model(a));
      chk("src2",  src2,  rd_model(b));
      chk("sum",   sum,   exp_sum);
      chk("wen",   {63'd0, wen}, {63'd0, is_addi});
      chk("wdata", wdata, is_addi ? exp_sum : 64'd0);
      chk("dnpc",  dnpc,  p + 64'd4);
      @(posedge clk);
      if (is_addi && d != 5'd0) model[d] = exp_sum;
      @(negedge clk);
   endtask

   initial begin
      rst = 1'b1; imm_I = 64'd77; rd = 5'd0; rs1 = 5'd9; rs2 = 5'd17;
      opcode = 10'd1; pc = 64'h1000;
      clear_model();
      #2;
      chk("rst_src1", src1, 64'd0);
      chk("rst_src2", src2, 64'd0);
      chk("rst_sum",  sum,  64'd77);
      chk("rst_dnpc", dnpc, 64'h1004);
      @(negedge clk);
      rst = 1'b0;

      // Write x5, then assert reset between edges: clear is immediate.
      instr(10'd1, 5'd5, 5'd0, 5'd0, 64'd123, 64'd0);
      rs1 = 5'd5; opcode = 10'd0; #1;
      chk("x5_before_rst", src1, 64'd123);
      rst = 1'b1; #1;
      chk("x5_async_rst", src1, 64'd0);
      clear_model();
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 32; i++) begin
         rs1 = 5'(i); #1;
         chk("post_rst_read", src1, 64'd0);
      end

      // ADDI sequence and sign-extended negative immediate.
      instr(10'd1, 5'd3, 5'd0, 5'd0, 64'd42, 64'h8000_0000);
      instr(10'd1, 5'd4, 5'd3, 5'd3, 64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFC);
      rs1 = 5'd4; rs2 = 5'd3; #1;
      chk("x4_eq_40", src1, 64'd40);
      chk("x3_eq_42", src2, 64'd42);

      // Non-ADDI opcode leaves x6 untouched.
      instr(10'b10, 5'd6, 5'd0, 5'd6, 64'd7, 64'd0);
      instr(10'd0, 5'd0, 5'd6, 5'd6, 64'd0, 64'd0);

      // x0 is never written.
      instr(10'd1, 5'd0, 5'd0, 5'd0, 64'd99, 64'd0);
      instr(10'd0, 5'd0, 5'd0, 5'd0, 64'd0, 64'd0);

      // Wrap-around and no bypass on read-modify-write of x7.
      instr(10'd1, 5'd7, 5'd0, 5'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0);
      instr(10'd1, 5'd7, 5'd7, 5'd7, 64'd1, 64'd0);
      rs1 = 5'd7; #1;
      chk("x7_wrapped", src1, 64'd0);

      // Random instructions, half of them ADDI, occasional rs1==rs2.
      for (int n = 0; n < 300; n++) begin
         logic [9:0] op;
         logic [4:0] a, b;
         op = ($urandom_range(0, 1) == 0) ? 10'd1 : 10'($urandom);
         a  = 5'($urandom);
         b  = ($urandom_range(0, 3) == 0) ? a : 5'($urandom);
         instr(op, 5'($urandom), a, b, {$urandom, $urandom}, {$urandom, $urandom});
      end

      $display("%0d/%0d checks passed", pass_cnt, check_cnt);
      $finish;
   end

endmodule
